// File: rtl/ice_uart_deframer_if.sv
// Handshake bundle between the UART byte deframer and its consumers.
interface ice_uart_deframer_if;
    logic [7:0] rx_data;
    logic       rx_latch;
    logic       hdr_valid;
    logic       hdr_ready;
    logic [7:0] hdr_type;
    logic [7:0] hdr_id;
    logic [7:0] hdr_len;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       err_timeout;
    logic       err_overflow;
    logic       err_clear;
    logic       busy;

    // Deframer side
    modport master (
        input  rx_data, rx_latch, hdr_ready, out_ready, err_clear,
        output hdr_valid, hdr_type, hdr_id, hdr_len,
        output out_data, out_last, out_valid,
        output err_timeout, err_overflow, busy
    );

    // Byte source / header and payload consumer side
    modport slave (
        output rx_data, rx_latch, hdr_ready, out_ready, err_clear,
        input  hdr_valid, hdr_type, hdr_id, hdr_len,
        input  out_data, out_last, out_valid,
        input  err_timeout, err_overflow, busy
    );
endinterface

// File: rtl/ice_uart_deframer.sv
// ICE host frame deframer: [type][id][len N][N payload] -> header register + payload FIFO.
module ice_uart_deframer #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic                 clk,
    input logic                 reset,
    ice_uart_deframer_if.master bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_TYPE,
        S_ID,
        S_LEN,
        S_PAYLOAD,
        S_SKIP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      type_q, type_d;
    logic [7:0]      id_q, id_d;
    logic [7:0]      rem_q, rem_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            hdr_valid_q, hdr_valid_d;
    logic [7:0]      hdr_type_q, hdr_type_d;
    logic [7:0]      hdr_id_q, hdr_id_d;
    logic [7:0]      hdr_len_q, hdr_len_d;
    logic            err_tmo_q, err_tmo_d;
    logic            err_ovf_q, err_ovf_d;
    logic            busy_q;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [8:0]      mem_q [FIFO_DEPTH];
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_last_q, out_last_d;

    logic            full_c;
    logic            pop_c;
    logic            hdr_acc_c;
    logic            want_push_c;
    logic            push_c;
    logic [8:0]      push_data_c;
    logic            set_ovf_c;
    logic            set_tmo_c;
    logic            empty_d_c;
    logic [8:0]      head_c;

    // FIFO status and handshake qualifiers
    always_comb begin
        full_c    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop_c     = out_valid_q & bus.out_ready;
        hdr_acc_c = hdr_valid_q & bus.hdr_ready;
    end

    // Frame parser next state; a timeout outranks a byte arriving on the same cycle
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        id_d        = id_q;
        rem_d       = rem_q;
        hdr_valid_d = hdr_valid_q & ~hdr_acc_c;
        hdr_type_d  = hdr_type_q;
        hdr_id_d    = hdr_id_q;
        hdr_len_d   = hdr_len_q;
        want_push_c = 1'b0;
        push_data_c = 9'(0);
        set_ovf_c   = 1'b0;
        set_tmo_c   = 1'b0;

        if (bus.rx_latch || state_q == S_TYPE) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (state_q != S_TYPE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
            state_d   = S_TYPE;
            set_tmo_c = 1'b1;
        end else if (bus.rx_latch) begin
            case (state_q)
                S_TYPE: begin
                    type_d  = bus.rx_data;
                    state_d = S_ID;
                end
                S_ID: begin
                    id_d    = bus.rx_data;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    rem_d = bus.rx_data;
                    if (!hdr_valid_q || hdr_acc_c) begin
                        hdr_valid_d = 1'b1;
                        hdr_type_d  = type_q;
                        hdr_id_d    = id_q;
                        hdr_len_d   = bus.rx_data;
                        state_d     = (bus.rx_data == 8'd0) ? S_TYPE : S_PAYLOAD;
                    end else begin
                        set_ovf_c = 1'b1;
                        state_d   = (bus.rx_data == 8'd0) ? S_TYPE : S_SKIP;
                    end
                end
                S_PAYLOAD: begin
                    want_push_c = 1'b1;
                    push_data_c = {(rem_q == 8'd1), bus.rx_data};
                    rem_d       = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = S_TYPE;
                    end
                end
                S_SKIP: begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = S_TYPE;
                    end
                end
                default: state_d = S_TYPE;
            endcase
        end

        push_c = want_push_c & ~full_c;
        if (want_push_c && full_c) begin
            set_ovf_c = 1'b1;
        end

        err_tmo_d = set_tmo_c ? 1'b1 : (bus.err_clear ? 1'b0 : err_tmo_q);
        err_ovf_d = set_ovf_c ? 1'b1 : (bus.err_clear ? 1'b0 : err_ovf_q);
    end

    // FIFO pointers and registered head; bypass covers a push landing in the new head slot
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(push_c);
        rd_ptr_d  = rd_ptr_q + PW'(pop_c);
        empty_d_c = (wr_ptr_d == rd_ptr_d);
        if (push_c && rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0]) begin
            head_c = push_data_c;
        end else begin
            head_c = mem_q[rd_ptr_d[AW-1:0]];
        end
        out_valid_d = ~empty_d_c;
        out_data_d  = empty_d_c ? 8'd0 : head_c[7:0];
        out_last_d  = empty_d_c ? 1'b0 : head_c[8];
    end

    // Payload storage
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_c;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_TYPE;
            type_q      <= 8'd0;
            id_q        <= 8'd0;
            rem_q       <= 8'd0;
            tmo_q       <= '0;
            hdr_valid_q <= 1'b0;
            hdr_type_q  <= 8'd0;
            hdr_id_q    <= 8'd0;
            hdr_len_q   <= 8'd0;
            err_tmo_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            id_q        <= id_d;
            rem_q       <= rem_d;
            tmo_q       <= tmo_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_type_q  <= hdr_type_d;
            hdr_id_q    <= hdr_id_d;
            hdr_len_q   <= hdr_len_d;
            err_tmo_q   <= err_tmo_d;
            err_ovf_q   <= err_ovf_d;
            busy_q      <= (state_d != S_TYPE);
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.hdr_valid    = hdr_valid_q;
    assign bus.hdr_type     = hdr_type_q;
    assign bus.hdr_id       = hdr_id_q;
    assign bus.hdr_len      = hdr_len_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.err_timeout  = err_tmo_q;
    assign bus.err_overflow = err_ovf_q;
    assign bus.busy         = busy_q;

endmodule
